// File: rtl/control_regs.sv
// CPU control register on the SPI bus: level reset/ready bits, a timed reset pulse,
// single-cycle CPU stepping, and registered readback of control and status.
module control_regs #(
  parameter int                    ADDR_WIDTH       = 17,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 17'hE80F,
  parameter int                    RES_PULSE_CYCLES = 16
) (
  input  logic                  strobe_clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [7:0]            spi_data_i,
  input  logic                  spi_wr_en_i,
  input  logic                  spi_rd_en_i,
  input  logic                  cpu_cycle_done_i,
  output logic [7:0]            spi_rd_data_o,
  output logic                  cpu_res_o,
  output logic                  cpu_ready_o,
  output logic                  step_busy_o
);

  localparam int CW = $clog2(RES_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(RES_PULSE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } step_state_t;

  logic              r_res_n;
  logic              r_ready;
  logic [CW-1:0]     r_count;
  step_state_t       r_state;
  logic [7:0]        r_rd_data;
  logic              r_cpu_res;
  logic              r_cpu_ready;
  logic              r_step_busy;

  logic              w_wr_hit;
  logic              w_rd_hit;
  logic              w_res_n_nxt;
  logic              w_ready_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic              w_res_nxt;
  step_state_t       w_state_nxt;
  logic [3:0]        w_unused_data;

  assign w_wr_hit      = spi_wr_en_i && (spi_addr_i == BASE_ADDR);
  assign w_rd_hit      = spi_rd_en_i && (spi_addr_i == BASE_ADDR);
  assign w_unused_data = spi_data_i[7:4];

  // Next control state; the step decision uses the CPU reset level as it will be after this write.
  always_comb begin
    w_res_n_nxt = r_res_n;
    w_ready_nxt = r_ready;
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_wr_hit) begin
      w_res_n_nxt = spi_data_i[0];
      w_ready_nxt = spi_data_i[1];
    end else begin
      w_res_n_nxt = r_res_n;
      w_ready_nxt = r_ready;
    end
    if (w_wr_hit && spi_data_i[3]) begin
      w_count_nxt = PULSE_LOAD;
    end else if (r_count != CNT_ZERO) begin
      w_count_nxt = r_count - CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
    w_res_nxt = !w_res_n_nxt || (w_count_nxt != CNT_ZERO);
    case (r_state)
      ST_IDLE: begin
        if (w_wr_hit && spi_data_i[2] && !spi_data_i[1] && !w_res_nxt) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (cpu_cycle_done_i || (w_wr_hit && (spi_data_i[1] || w_res_nxt))) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, step FSM and output registers; outputs are loaded from next-state values.
  always_ff @(posedge strobe_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_res_n     <= 1'b0;
      r_ready     <= 1'b0;
      r_count     <= CNT_ZERO;
      r_state     <= ST_IDLE;
      r_rd_data   <= 8'h00;
      r_cpu_res   <= 1'b1;
      r_cpu_ready <= 1'b0;
      r_step_busy <= 1'b0;
    end else begin
      r_res_n     <= w_res_n_nxt;
      r_ready     <= w_ready_nxt;
      r_count     <= w_count_nxt;
      r_state     <= w_state_nxt;
      r_cpu_res   <= w_res_nxt;
      r_cpu_ready <= w_ready_nxt || (w_state_nxt == ST_STEP);
      r_step_busy <= (w_state_nxt == ST_STEP);
      // Readback reflects the state before any same-cycle write.
      if (w_rd_hit) begin
        r_rd_data <= {4'b0000, (r_count != CNT_ZERO), (r_state == ST_STEP), r_ready, r_res_n};
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign spi_rd_data_o = r_rd_data;
  assign cpu_res_o     = r_cpu_res;
  assign cpu_ready_o   = r_cpu_ready;
  assign step_busy_o   = r_step_busy;

endmodule

// File: tb/tb_control_regs.sv
// Directed and randomized bench for control_regs, checked against a behavioural model.
module tb_control_regs;

  localparam logic [16:0] BASE = 17'hE80F;
  localparam int          NPULSE = 16;

  logic        clk;
  logic        reset_i;
  logic [16:0] spi_addr_i;
  logic [7:0]  spi_data_i;
  logic        spi_wr_en_i;
  logic        spi_rd_en_i;
  logic        cpu_cycle_done_i;
  logic [7:0]  spi_rd_data_o;
  logic        cpu_res_o;
  logic        cpu_ready_o;
  logic        step_busy_o;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit       m_res_n, m_ready, m_stepping;
  int       m_pulse_left;
  bit [7:0] m_rd;

  control_regs #(.ADDR_WIDTH(17), .BASE_ADDR(BASE), .RES_PULSE_CYCLES(NPULSE)) dut (
    .strobe_clk_i     (clk),
    .reset_i          (reset_i),
    .spi_addr_i       (spi_addr_i),
    .spi_data_i       (spi_data_i),
    .spi_wr_en_i      (spi_wr_en_i),
    .spi_rd_en_i      (spi_rd_en_i),
    .cpu_cycle_done_i (cpu_cycle_done_i),
    .spi_rd_data_o    (spi_rd_data_o),
    .cpu_res_o        (cpu_res_o),
    .cpu_ready_o      (cpu_ready_o),
    .step_busy_o      (step_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_res_n = 1'b0; m_ready = 1'b0; m_stepping = 1'b0; m_pulse_left = 0; m_rd = 8'h00;
  endtask

  function automatic bit model_cpu_res();
    return !m_res_n || (m_pulse_left > 0);
  endfunction

  // apply one clock edge of the stated rules to the model
  task automatic model_edge(input bit wr, input bit rd, input logic [16:0] a, input logic [7:0] d,
                            input bit done);
    bit hit_w, hit_r;
    hit_w = wr && (a == BASE);
    hit_r = rd && (a == BASE);
    if (hit_r) m_rd = {4'h0, m_pulse_left > 0, m_stepping, m_ready, m_res_n};
    if (hit_w) begin
      m_res_n = d[0];
      m_ready = d[1];
    end
    if (hit_w && d[3]) m_pulse_left = NPULSE;
    else if (m_pulse_left > 0) m_pulse_left = m_pulse_left - 1;
    if (m_stepping) begin
      if (done || (hit_w && (d[1] || model_cpu_res()))) m_stepping = 1'b0;
    end else if (hit_w && d[2] && !d[1] && !model_cpu_res()) begin
      m_stepping = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".res"},   {7'd0, cpu_res_o},   {7'd0, model_cpu_res()});
    check_eq({tag, ".ready"}, {7'd0, cpu_ready_o}, {7'd0, m_ready || m_stepping});
    check_eq({tag, ".busy"},  {7'd0, step_busy_o}, {7'd0, m_stepping});
    check_eq({tag, ".rd"},    spi_rd_data_o,       m_rd);
  endtask

  // one clock cycle of stimulus; called #1 after a rising edge
  task automatic cyc(input bit wr, input bit rd, input logic [16:0] a, input logic [7:0] d,
                     input bit done, input string tag);
    spi_wr_en_i = wr; spi_rd_en_i = rd; spi_addr_i = a; spi_data_i = d; cpu_cycle_done_i = done;
    @(posedge clk);
    model_edge(wr, rd, a, d, done);
    #1;
    spi_wr_en_i = 1'b0; spi_rd_en_i = 1'b0; cpu_cycle_done_i = 1'b0;
    check_outputs(tag);
  endtask

  task automatic wr(input logic [7:0] d, input string tag);
    cyc(1'b1, 1'b0, BASE, d, 1'b0, tag);
  endtask

  task automatic rd(input string tag);
    cyc(1'b0, 1'b1, BASE, 8'h00, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 8'h00, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int highs;
    logic [16:0] a;
    logic [7:0]  d;
    reset_i = 1'b1; spi_addr_i = BASE; spi_data_i = 8'h00;
    spi_wr_en_i = 1'b0; spi_rd_en_i = 1'b0; cpu_cycle_done_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_res", {7'd0, cpu_res_o}, 8'h01);
    check_eq("reset_ready", {7'd0, cpu_ready_o}, 8'h00);
    check_eq("reset_busy", {7'd0, step_busy_o}, 8'h00);
    check_eq("reset_rd", spi_rd_data_o, 8'h00);
    reset_i = 1'b0;

    // level control and address decode
    wr(8'h03, "lvl");
    check_eq("lvl_res", {7'd0, cpu_res_o}, 8'h00);
    check_eq("lvl_ready", {7'd0, cpu_ready_o}, 8'h01);
    rd("lvl_rd");
    check_eq("lvl_readback", spi_rd_data_o, 8'h03);
    cyc(1'b1, 1'b0, BASE - 17'd1, 8'h00, 1'b0, "miss");
    check_eq("miss_res", {7'd0, cpu_res_o}, 8'h00);
    check_eq("miss_ready", {7'd0, cpu_ready_o}, 8'h01);

    // single reset pulse
    wr(8'h01, "pre_pulse");
    highs = 0;
    wr(8'h09, "pulse");
    if (cpu_res_o) highs++;
    rd("pulse_rd");
    if (cpu_res_o) highs++;
    check_eq("pulse_rd_bit3", spi_rd_data_o & 8'h08, 8'h08);
    for (int i = 0; i < 30; i++) begin
      idle(1, "pulse_wait");
      if (cpu_res_o) highs++;
    end
    check_eq("pulse_len", 8'(highs), 8'd16);

    // extended pulse: second PULSE write at cycle 10
    highs = 0;
    wr(8'h09, "pulse2a");
    if (cpu_res_o) highs++;
    for (int i = 0; i < 9; i++) begin
      idle(1, "pulse2_wait");
      if (cpu_res_o) highs++;
    end
    wr(8'h09, "pulse2b");
    if (cpu_res_o) highs++;
    for (int i = 0; i < 30; i++) begin
      idle(1, "pulse2_tail");
      if (cpu_res_o) highs++;
    end
    check_eq("pulse_ext_len", 8'(highs), 8'd26);

    // single step
    wr(8'h01, "step_pre");
    wr(8'h05, "step");
    check_eq("step_ready", {7'd0, cpu_ready_o}, 8'h01);
    check_eq("step_busy", {7'd0, step_busy_o}, 8'h01);
    idle(4, "step_hold");
    cyc(1'b0, 1'b0, BASE, 8'h00, 1'b1, "step_done");
    check_eq("step_done_ready", {7'd0, cpu_ready_o}, 8'h00);
    check_eq("step_done_busy", {7'd0, step_busy_o}, 8'h00);
    rd("step_rd");
    check_eq("step_readback", spi_rd_data_o, 8'h01);

    // step rejection and abandonment
    wr(8'h04, "rej_resn");
    check_eq("rej_resn_busy", {7'd0, step_busy_o}, 8'h00);
    wr(8'h07, "rej_ready");
    check_eq("rej_ready_ready", {7'd0, cpu_ready_o}, 8'h01);
    check_eq("rej_ready_busy", {7'd0, step_busy_o}, 8'h00);
    wr(8'h01, "ab_pre");
    wr(8'h05, "ab_step");
    wr(8'h03, "ab_run");
    check_eq("ab_busy", {7'd0, step_busy_o}, 8'h00);
    check_eq("ab_ready", {7'd0, cpu_ready_o}, 8'h01);

    // STEP write coinciding with cpu_cycle_done_i
    wr(8'h01, "co_pre");
    cyc(1'b1, 1'b0, BASE, 8'h05, 1'b1, "co_step");
    idle(3, "co_hold");
    check_eq("co_busy", {7'd0, step_busy_o}, 8'h01);
    cyc(1'b0, 1'b0, BASE, 8'h00, 1'b1, "co_done");
    check_eq("co_done_busy", {7'd0, step_busy_o}, 8'h00);

    // reset mid-pulse then readback
    wr(8'h0B, "rst_pulse");
    idle(3, "rst_pulse_run");
    do_reset("rst_mid");
    rd("rst_rd");
    check_eq("rst_readback", spi_rd_data_o, 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 17'd1;
        1:       a = 17'($urandom);
        default: a = BASE;
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d[1] = 1'b0;
      if ($urandom_range(0, 4) == 0) d[3] = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), a, d,
            ($urandom_range(0, 7) == 0), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
